iter_divider: RTL and testbench

//  Parametrised iterative radix-2 restoring divider for the EX stage. It replaces the vendor-IP

---
 rtl/iter_divider.sv | 133 +++++++++++++
 tb/tb_iter_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for the EX stage.
// Signed and unsigned ops share one datapath: operands are converted to
// magnitudes at accept, divided unsigned, then sign-corrected in FIX.
module iter_divider #(
  parameter int WIDTH       = 32,
  parameter int ZERO_BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvs;
  logic             neg_q, neg_r, is_mod, op_ok, dvs_zero;

  // op decode, priority [0] > [1] > [2] > [3]; op==0 is a bad op
  logic dec_ok, dec_signed, dec_mod;
  always_comb begin
    dec_ok     = 1'b1;
    dec_signed = 1'b0;
    dec_mod    = 1'b0;
    if (op[0])      dec_signed = 1'b1;
    else if (op[1]) dec_signed = 1'b0;
    else if (op[2]) begin dec_signed = 1'b1; dec_mod = 1'b1; end
    else if (op[3]) dec_mod = 1'b1;
    else            dec_ok = 1'b0;
  end

  logic             a_neg, b_neg, src_zero, accept, bypass;
  logic [WIDTH-1:0] a_mag, b_mag, byp_res;
  assign a_neg    = dec_signed & src1[WIDTH-1];
  assign b_neg    = dec_signed & src2[WIDTH-1];
  assign a_mag    = a_neg ? -src1 : src1;
  assign b_mag    = b_neg ? -src2 : src2;
  assign src_zero = (src2 == '0);
  assign accept   = (state == IDLE) & in_valid & ~flush;
  assign bypass   = (ZERO_BYPASS != 0) & src_zero;
  // divide-by-zero answer produced directly when the engine is skipped
  assign byp_res  = !dec_ok ? '0 : (dec_mod ? src1 : '1);

  // one restoring step: shift in the next dividend bit, trial-subtract
  logic [WIDTH:0] rem_sh, diff;
  logic           q_bit;
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign q_bit  = ~diff[WIDTH];

  // the partial remainder stays below the divisor, so its top bit is always 0
  logic rem_msb_unused;
  assign rem_msb_unused = rem[WIDTH];

  // sign correction; a zero divisor keeps the all-ones quotient unnegated
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;
  assign q_fix   = (neg_q & ~dvs_zero) ? -quo : quo;
  assign r_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign fix_res = !op_ok ? '0 : (is_mod ? r_fix : q_fix);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and handshake outputs; flush wins over everything
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (in_valid) state_nxt = bypass ? DONE : CALC;
        CALC: if (cnt == '0) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // datapath: operand capture, iteration, result formation
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_mod   <= 1'b0;
      op_ok    <= 1'b0;
      dvs_zero <= 1'b0;
      result   <= '0;
    end else if (!flush) begin
      if (accept) begin
        cnt      <= CW'(WIDTH-1);
        rem      <= '0;
        quo      <= a_mag;
        dvs      <= b_mag;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        is_mod   <= dec_mod;
        op_ok    <= dec_ok;
        dvs_zero <= src_zero;
        if (bypass) result <= byp_res;
      end else if (state == CALC) begin
        rem <= q_bit ? diff : rem_sh;
        quo <= {quo[WIDTH-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end else if (state == FIX) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed checks of iter_divider at WIDTH=32 (with and without zero bypass)
// plus a WIDTH=8 sweep against an integer-arithmetic reference.
module tb_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] src1, src2;
  logic        in_ready_a, out_valid_a, busy_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [31:0] result_a, result_b;

  logic       flush_c, in_valid_c, out_ready_c, in_ready_c, out_valid_c, busy_c;
  logic [3:0] op_c;
  logic [7:0] src1_c, src2_c, result_c;

  iter_divider #(.WIDTH(32), .ZERO_BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .busy(busy_a));

  iter_divider #(.WIDTH(32), .ZERO_BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .busy(busy_b));

  iter_divider #(.WIDTH(8), .ZERO_BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .op(op_c), .src1(src1_c), .src2(src2_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .result(result_c), .busy(busy_c));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(in_ready_a && in_ready_b) && n < 200) begin tick(); n++; end
    if (n >= 200) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // issue one op to both 32-bit engines, watch engine sel (0=bypass, 1=no bypass)
  task automatic run_op(input string tag, input int sel, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int  lat;
    logic ok;
    wait_idle(tag);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; src1 = 32'hDEADBEEF; src2 = 32'h13579BDF;
    lat = 1; ok = 1'b0;
    while (lat < 200) begin
      if ((sel == 0) ? out_valid_a : out_valid_b) begin ok = 1'b1; break; end
      tick();
      lat++;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk(tag, (sel == 0) ? result_a : result_b, exp);
      if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  function automatic logic [7:0] model8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    logic [7:0] q, r, uq, ur;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 8'd0) begin
      q = 8'hFF; r = a; uq = 8'hFF; ur = a;
    end else begin
      uq = a / b; ur = a % b;
      q = 8'(sa / sb); r = 8'(sa % sb);
    end
    if (o[0])      return q;
    else if (o[1]) return uq;
    else if (o[2]) return r;
    else if (o[3]) return ur;
    return 8'h00;
  endfunction

  task automatic run8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready_c && n < 50) begin tick(); n++; end
    op_c = o; src1_c = a; src2_c = b; in_valid_c = 1'b1;
    tick();
    in_valid_c = 1'b0; src1_c = 8'h5A; src2_c = 8'hA5;
    n = 0;
    while (!out_valid_c && n < 50) begin tick(); n++; end
    if (!out_valid_c) chk("w8_timeout", 32'd0, 32'd1);
    else if (result_c !== model8(o, a, b)) begin
      chk($sformatf("w8 op%h %h/%h", o, a, b), 32'(result_c), 32'(model8(o, a, b)));
    end else n_chk++;
  endtask

  initial begin
    logic seen;
    int   n;
    logic [3:0] o;
    logic [7:0] a, b;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; src1 = '0; src2 = '0;
    flush_c = 1'b0; in_valid_c = 1'b0; out_ready_c = 1'b1; op_c = 4'd0; src1_c = '0; src2_c = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_busy",      32'(busy_a),      32'd0);
    chk("rst_result",    result_a,         32'd0);
    chk("rst_in_ready",  32'(in_ready_a),  32'd1);

    // basic unsigned / signed quotient and remainder
    run_op("divu_100_7", 0, 4'b0010, 32'd100, 32'd7, 32'd14, 34);
    run_op("modu_100_7", 0, 4'b1000, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2",   0, 4'b0001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("mod_m7_2",   0, 4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("div_7_m2",   0, 4'b0001, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run_op("mod_7_m2",   0, 4'b0100, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    run_op("div_ovf",    0, 4'b0001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    run_op("mod_ovf",    0, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);

    // divide by zero, bypass and full-latency engines
    run_op("divu_z_byp", 0, 4'b0010, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("modu_z_byp", 0, 4'b1000, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu_z_full", 1, 4'b0010, 32'd5, 32'd0, 32'hFFFFFFFF, 34);
    run_op("modu_z_full", 1, 4'b1000, 32'd5, 32'd0, 32'd5, 34);
    run_op("div_negz_full", 1, 4'b0001, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 34);
    run_op("mod_negz_full", 1, 4'b0100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 34);

    // bad and multi-hot ops
    run_op("op_zero",   0, 4'b0000, 32'd100, 32'd7, 32'd0, 34);
    run_op("op_1100",   0, 4'b1100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("op_0011",   0, 4'b0011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);

    // flush in CALC cycle 10
    wait_idle("flush");
    op = 4'b0010; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready_a), 32'd1);
    chk("flush_busy",     32'(busy_a),     32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid_a || out_valid_b) seen = 1'b1;
      tick();
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    // flush and in_valid together: no accept
    op = 4'b0010; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", 32'(busy_a), 32'd0);
    run_op("divu_9_3", 0, 4'b0010, 32'd9, 32'd3, 32'd3, 34);

    // consumer stalls 5 cycles in DONE while new requests are offered
    wait_idle("hold");
    out_ready = 1'b0;
    op = 4'b0010; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_a && n < 100) begin tick(); n++; end
    if (!out_valid_a) chk("hold_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; op = 4'b0010; src1 = 32'd50; src2 = 32'd5;
    repeat (5) begin
      chk("hold_valid",    32'(out_valid_a), 32'd1);
      chk("hold_result",   result_a,         32'd14);
      chk("hold_in_ready", 32'(in_ready_a),  32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("hold_release_valid", 32'(out_valid_a), 32'd0);
    chk("hold_release_ready", 32'(in_ready_a),  32'd1);

    // reset mid-op clears a previously held non-zero result
    wait_idle("rst_mid");
    op = 4'b0010; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_result",   result_a,         32'd0);
    chk("rst_mid_valid",    32'(out_valid_a), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready_a),  32'd1);

    // WIDTH=8 corners then random sweep
    run8(4'b0001, 8'h80, 8'hFF);
    run8(4'b0100, 8'h80, 8'hFF);
    run8(4'b0001, 8'h81, 8'h00);
    run8(4'b0100, 8'h81, 8'h00);
    run8(4'b0010, 8'hFF, 8'h01);
    run8(4'b1000, 8'hFE, 8'hFF);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: o = 4'b0001;
        1: o = 4'b0010;
        2: o = 4'b0100;
        3: o = 4'b1000;
        default: o = 4'($urandom_range(0, 15));
      endcase
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run8(o, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
